// File: rtl/return_stack.sv
// Return-address LIFO: register array plus stack pointer, with a registered
// top-of-stack copy so pop_data is valid in the same cycle as the pop strobe.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pushEn,
  input  logic                     popEn,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     stackFull,
  output logic                     stackEmpty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] cnt_t;
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t ONE_CNT  = cnt_t'(1);
  localparam cnt_t TWO_CNT  = cnt_t'(2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] tos;

  logic             is_full;
  logic             is_empty;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             ovf_evt;
  logic             udf_evt;
  logic             mem_we;
  cnt_t             cnt_m1;
  cnt_t             cnt_m2;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    below_idx;
  logic [WIDTH-1:0] below_val;
  logic [WIDTH-1:0] tos_after_pop;

  assign is_full    = (count == FULL_CNT);
  assign is_empty   = (count == '0);
  assign stackFull  = is_full;
  assign stackEmpty = is_empty;
  assign pop_data   = tos;

  // Request decode: replace wins over push/pop when there is a top entry;
  // a combined request on an empty stack degrades to push plus underflow.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    unique case ({pushEn, popEn})
      2'b10: begin
        if (is_full) ovf_evt = 1'b1;
        else         do_push = 1'b1;
      end
      2'b01: begin
        if (is_empty) udf_evt = 1'b1;
        else          do_pop  = 1'b1;
      end
      2'b11: begin
        if (is_empty) begin
          udf_evt = 1'b1;
          do_push = 1'b1;
        end else begin
          do_repl = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cnt_m1    = count - ONE_CNT;
  assign cnt_m2    = count - TWO_CNT;
  assign wr_idx    = do_repl ? cnt_m1[AW-1:0] : count[AW-1:0];
  assign below_idx = cnt_m2[AW-1:0];
  assign below_val = mem[below_idx];

  // The entry beneath the current top becomes the new top on a pop.
  assign tos_after_pop = (count == ONE_CNT) ? '0 : below_val;

  assign mem_we = rst_n & (do_push | do_repl);

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      tos       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        count <= count + ONE_CNT;
        tos   <= push_data;
      end else if (do_pop) begin
        count <= cnt_m1;
        tos   <= tos_after_pop;
      end else if (do_repl) begin
        tos   <= push_data;
      end
      overflow  <= ovf_evt | (overflow  & ~err_clr);
      underflow <= udf_evt | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: queue reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_return_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_en = 1'b0;
  logic             pop_en = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic [WIDTH-1:0] pop_data;
  logic             stack_full;
  logic             stack_empty;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [WIDTH-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  bit ev_o;
  bit ev_u;

  always #5 clk = ~clk;

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pushEn(push_en), .popEn(pop_en),
    .push_data(push_data), .err_clr(err_clr), .pop_data(pop_data),
    .stackFull(stack_full), .stackEmpty(stack_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    if (q.size() == 0) return '0;
    return q[q.size()-1];
  endfunction

  // Reference model: a plain queue of entries, top at the back.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      ev_o = 1'b0;
      ev_u = 1'b0;
      if (push_en && pop_en && q.size() != 0) begin
        q[q.size()-1] = push_data;
      end else begin
        if (pop_en) begin
          if (q.size() == 0) ev_u = 1'b1;
          else void'(q.pop_back());
        end
        if (push_en) begin
          if (q.size() == DEPTH) ev_o = 1'b1;
          else q.push_back(push_data);
        end
      end
      m_ovf = ev_o | (m_ovf & !err_clr);
      m_udf = ev_u | (m_udf & !err_clr);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_pop_data", pop_data, m_top());
      check("cyc_count", count, q.size());
      check("cyc_full", stack_full, q.size() == DEPTH);
      check("cyc_empty", stack_empty, q.size() == 0);
      check("cyc_overflow", overflow, m_ovf);
      check("cyc_underflow", underflow, m_udf);
      check("cyc_count_range", count <= DEPTH, 1);
    end
  end

  task automatic drive(input logic p, input logic o, input logic [WIDTH-1:0] d, input logic c);
    push_en = p; pop_en = o; push_data = d; err_clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_pop_data"}, pop_data, 0);
    check({tag, "_empty"}, stack_empty, 1);
    check({tag, "_full"}, stack_full, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_underflow"}, underflow, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Three pushes then three show-ahead pops.
    drive(1, 0, 16'h1111, 0); tick();
    drive(1, 0, 16'h2222, 0); tick();
    drive(1, 0, 16'h3333, 0); tick();
    idle();
    check("lifo_count3", count, 3);
    check("lifo_top3", pop_data, 16'h3333);
    drive(0, 1, '0, 0); check("lifo_pop1", pop_data, 16'h3333); tick();
    drive(0, 1, '0, 0); check("lifo_pop2", pop_data, 16'h2222); tick();
    drive(0, 1, '0, 0); check("lifo_pop3", pop_data, 16'h1111); tick();
    idle();
    check("lifo_count0", count, 0);
    check("lifo_empty", stack_empty, 1);
    check("lifo_data0", pop_data, 0);

    // Fill, then overflow.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 0, WIDTH'(i), 0);
      tick();
    end
    idle();
    check("fill_full", stack_full, 1);
    drive(1, 0, 16'hFFFF, 0); tick(); idle();
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 8);
    check("ovf_top", pop_data, 16'h0008);
    do_reset();

    // Underflow and err_clr priority.
    drive(0, 1, '0, 0); tick(); idle();
    check("udf_flag", underflow, 1);
    check("udf_count", count, 0);
    check("udf_data", pop_data, 0);
    drive(0, 0, '0, 1); tick(); idle();
    check("udf_clr", underflow, 0);
    drive(0, 1, '0, 1); tick(); idle();
    check("udf_clr_prio", underflow, 1);
    drive(1, 1, 16'h00C0, 0); tick(); idle();
    check("empty_pushpop_count", count, 1);
    check("empty_pushpop_data", pop_data, 16'h00C0);
    do_reset();

    // Replace with count 2, then replace while full.
    drive(1, 0, 16'h0011, 0); tick();
    drive(1, 0, 16'h00AA, 0); tick();
    drive(1, 1, 16'h00BB, 0); check("repl_show", pop_data, 16'h00AA); tick();
    idle();
    check("repl_top", pop_data, 16'h00BB);
    check("repl_count", count, 2);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 16'h0030 + WIDTH'(i), 0);
      tick();
    end
    drive(1, 1, 16'h0077, 0); check("repl_full_show", pop_data, 16'h0035); tick();
    idle();
    check("repl_full_ovf", overflow, 0);
    check("repl_full_count", count, 8);
    check("repl_full_top", pop_data, 16'h0077);
    drive(0, 1, '0, 0); tick(); idle();
    check("repl_below", pop_data, 16'h0034);
    do_reset();

    // Asynchronous reset between edges with count 5.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'h0500 + WIDTH'(i), 0);
      tick();
    end
    idle();
    check("pre_async_count", count, 5);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    #1 rst_n = 1'b1;
    tick();
    drive(1, 0, 16'h1234, 0); tick(); idle();
    check("post_rst_count", count, 1);
    check("post_rst_data", pop_data, 16'h1234);

    // Reset held across a push edge aborts it; release acts on new inputs.
    drive(1, 0, 16'h5555, 0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 check("abort_count", count, 0);
    drive(1, 0, 16'h6666, 0);
    rst_n = 1'b1;
    tick(); tick(); idle();
    check("abort_next_count", count, 1);
    check("abort_next_data", pop_data, 16'h6666);
    do_reset();

    // Random traffic with phased push bias to visit full and empty.
    for (int i = 0; i < 10000; i++) begin
      int bias;
      bias = (i / 500) % 3 == 0 ? 70 : ((i / 500) % 3 == 1 ? 50 : 30);
      drive($urandom_range(99) < bias, $urandom_range(99) < 100 - bias,
            WIDTH'($urandom), $urandom_range(15) == 0);
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each stack entry.
REQ-002 Parameter DEPTH, default 8: number of entries, power of two, minimum 2.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port pushEn, input, 1: push request, driven by the decoder push strobe during e1.
REQ-006 Port popEn, input, 1: pop request, driven by the decoder pop strobe during e1.
REQ-007 Port push_data, input, WIDTH: value to push.
REQ-008 Port err_clr, input, 1: synchronous clear of the sticky error flags.
REQ-009 Port pop_data, output, WIDTH: current top-of-stack value, feeding both the register-file write mux and the PC load mux.
REQ-010 Port stackFull, output, 1: high when count == DEPTH.
REQ-011 Port stackEmpty, output, 1: high when count == 0.
REQ-012 Port count, output, log2(DEPTH)+1: number of valid entries.
REQ-013 Port overflow, output, 1: sticky flag, set by a push while full.
REQ-014 Port underflow, output, 1: sticky flag, set by a pop while empty.

Function
REQ-015 The block SHALL be a LIFO built from a DEPTH x WIDTH register array, a stack pointer (count) and a registered top-of-stack copy (tos).
REQ-016 pop_data SHALL equal tos, driven directly from a register with no combinational read of the array; it SHALL be 0 whenever stackEmpty = 1.
REQ-017 Show-ahead rule: pop_data SHALL be valid in the same cycle popEn is high, so the consumer captures it at that cycle's clock edge.
REQ-018 Push only, not full: at the edge, the array SHALL store push_data at index count, tos <= push_data, and count SHALL increment by 1.
REQ-019 Pop only, not empty: at the edge, count SHALL decrement by 1, and tos SHALL become the entry at index count-2, or 0 when the new count is 0.
REQ-020 Push and pop in the same cycle with count >= 1 (replace): the top entry and tos SHALL become push_data, and count SHALL be unchanged; this SHALL also apply when full, with no overflow.
REQ-021 Push and pop in the same cycle while empty: the pop SHALL be ignored and underflow SHALL set; the push SHALL proceed per REQ-018.
REQ-022 Push while full, with no pop: no state change except overflow <= 1.
REQ-023 Pop while empty, with no push: no state change except underflow <= 1.
REQ-024 stackFull and stackEmpty SHALL be decoded from the registered count only, so they change in the cycle after the causing edge.
REQ-025 err_clr SHALL clear overflow and underflow at the edge; a new error event in the same cycle SHALL take priority and leave the flag set.
REQ-026 Neither request high: all state SHALL hold.
REQ-027 count SHALL never exceed DEPTH and SHALL never wrap below 0.

Reset
REQ-028 While rst_n = 0: count = 0, tos = 0, pop_data = 0, stackEmpty = 1, stackFull = 0, overflow = 0, underflow = 0, asynchronously and regardless of clk.
REQ-029 Array contents SHALL NOT need a reset; they SHALL be unobservable while count = 0.
REQ-030 A reset asserted mid-sequence (e.g. during a push cycle) SHALL abort that operation; the first edge after deassertion SHALL act on the inputs present at that edge.

Verification
REQ-031 Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> count = 3, pop_data = 0x3333; then three pops -> pop_data shows 0x3333, then 0x2222, then 0x1111 in the pop cycles, and finally count = 0, stackEmpty = 1, pop_data = 0.
REQ-032 Push DEPTH values 0x0001..0x0008 -> stackFull = 1 the cycle after the 8th push; a 9th push of 0xFFFF -> overflow = 1, count = 8, pop_data = 0x0008.
REQ-033 Pop from empty -> underflow = 1, count = 0, pop_data = 0; err_clr one cycle -> underflow = 0; err_clr together with another empty pop -> underflow stays 1.
REQ-034 With count = 2 and top = 0x00AA, push 0x00BB and pop in the same cycle -> pop_data = 0x00AA in that cycle, then 0x00BB, count = 2; repeat while full -> no overflow.
REQ-035 With count = 5, assert rst_n = 0 between clock edges -> all outputs reach reset values immediately, without waiting for an edge; a push 0x1234 on the first edge after release -> count = 1, pop_data = 0x1234.
REQ-036 Random push/pop/err_clr stimulus for 10k cycles, compared cycle-by-cycle against a reference queue model, with count in range 0..DEPTH at all times -> zero mismatches.
